gpr_wb_arbiter: RTL and testbench

- Shares the single GPR write port between two writeback sources: EXU (ALU/CSR results) and LSU (load data).
- Tracks in-flight destination registers in a 32-entry scoreboard so decode can stall on RAW hazards.
- Sits between EXU/LSU and the GPR write port (w_en / w_rd_addr / w_data).
- Write port outputs are registered, giving one cycle of arbitration-to-write latency.

---
 rtl/gpr_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: shares the register-file write port between EXU and LSU
// and keeps a busy scoreboard for RAW stalls. Define GPR_WB_RR_EN for round-robin, else LSU has fixed priority.
module gpr_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic [DATA_WIDTH-1:0] w_data
);

  localparam int NumRegs = 1 << ADDR_WIDTH;

  logic                  exuGrant;
  logic                  lsuGrant;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] grantRd;
  logic [DATA_WIDTH-1:0] grantData;

  logic                  w_en_q;
  logic [ADDR_WIDTH-1:0] w_rd_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NumRegs-1:0]    busy_q, busy_d;

`ifdef GPR_WB_RR_EN
  // lastLsu_q=0 means EXU was last granted, so LSU wins the first conflict after reset
  logic lastLsu_q;

  always_comb begin
    exuGrant = 1'b0;
    lsuGrant = 1'b0;
    if (exu_valid && lsu_valid) begin
      lsuGrant = !lastLsu_q;
      exuGrant = lastLsu_q;
    end else begin
      exuGrant = exu_valid;
      lsuGrant = lsu_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastLsu_q <= 1'b0;
    end else if (exu_valid && lsu_valid) begin
      lastLsu_q <= lsuGrant;
    end
  end
`else
  always_comb begin
    lsuGrant = lsu_valid;
    exuGrant = exu_valid && !lsu_valid;
  end
`endif

  assign exu_ready = exuGrant && rst_n;
  assign lsu_ready = lsuGrant && rst_n;
  assign xfer      = exuGrant || lsuGrant;
  assign grantRd   = lsuGrant ? lsu_rd   : exu_rd;
  assign grantData = lsuGrant ? lsu_data : exu_data;

  // Writes to x0 are granted and captured but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_q      <= 1'b0;
      w_rd_addr_q <= '0;
      w_data_q    <= '0;
    end else begin
      w_en_q <= xfer && (grantRd != '0);
      if (xfer) begin
        w_rd_addr_q <= grantRd;
        w_data_q    <= grantData;
      end
    end
  end

  // Clear (flush or commit) is applied before set so a new in-flight writer wins
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else if (w_en_q) begin
      busy_d[w_rd_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy  = busy_q[q_rs1];
  assign rs2_busy  = busy_q[q_rs2];
  assign w_en      = w_en_q;
  assign w_rd_addr = w_rd_addr_q;
  assign w_data    = w_data_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: expected GPR writes are queued when a grant
// is driven and matched against the write port by a monitor.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        w_en;
  logic [4:0]  w_rd_addr;
  logic [31:0] w_data;

  int testsRun;
  int testsFailed;
  logic [36:0] sbQ[$];

  gpr_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .w_en(w_en), .w_rd_addr(w_rd_addr), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every enabled write on the port must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && w_en) begin
      logic [36:0] exp;
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", w_rd_addr, w_data);
      end else begin
        exp = sbQ.pop_front();
        if ({w_rd_addr, w_data} !== exp) begin
          testsFailed++;
          $display("[TB] FAIL write_port: got addr=%0d data=%h, expected addr=%0d data=%h",
                   w_rd_addr, w_data, exp[36:32], exp[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectBit(input string name, input logic got, input logic want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    q_rs1 = 5'd1; q_rs2 = 5'd2;
    #12;
    expectBit("reset_exu_ready", exu_ready, 1'b0);
    expectBit("reset_lsu_ready", lsu_ready, 1'b0);
    expectBit("reset_w_en", w_en, 1'b0);
    testsRun++;
    if (w_rd_addr !== 5'd0 || w_data !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_addr_data: got addr=%0d data=%h, expected 0/0", w_rd_addr, w_data);
    end
    expectBit("reset_rs1_busy", rs1_busy, 1'b0);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_exu;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
    #1;
    expectBit("single_exu_ready", exu_ready, 1'b1);
    expectBit("single_lsu_ready", lsu_ready, 1'b0);
    sbQ.push_back({5'd5, 32'h1234});
    tick();
    exu_valid = 1'b0;
    expectBit("single_w_en_set", w_en, 1'b1);
    tick();
    expectBit("single_w_en_clear", w_en, 1'b0);
  endtask

  task automatic test_conflict;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hE0E0_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hD0D0_0004;
    #1;
    expectBit("conflict1_lsu_ready", lsu_ready, 1'b1);
    expectBit("conflict1_exu_ready", exu_ready, 1'b0);
    sbQ.push_back({5'd4, 32'hD0D0_0004});
    tick();
`ifdef GPR_WB_RR_EN
    expectBit("conflict2_exu_ready", exu_ready, 1'b1);
    expectBit("conflict2_lsu_ready", lsu_ready, 1'b0);
    sbQ.push_back({5'd3, 32'hE0E0_0003});
`else
    expectBit("conflict2_exu_ready", exu_ready, 1'b0);
    expectBit("conflict2_lsu_ready", lsu_ready, 1'b1);
    sbQ.push_back({5'd4, 32'hD0D0_0004});
`endif
    testsRun++;
    if (w_rd_addr !== 5'd4) begin
      testsFailed++;
      $display("[TB] FAIL conflict_first_addr: got %0d, expected 4", w_rd_addr);
    end
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard;
    issue_valid = 1'b1; issue_rd = 5'd7; q_rs1 = 5'd7; q_rs2 = 5'd0;
    #1;
    expectBit("sb_busy_before_issue", rs1_busy, 1'b0);
    tick();
    issue_valid = 1'b0;
    expectBit("sb_busy_after_issue", rs1_busy, 1'b1);
    expectBit("sb_x0_busy", rs2_busy, 1'b0);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hCAFE_0007;
    #1;
    expectBit("sb_lsu_ready", lsu_ready, 1'b1);
    sbQ.push_back({5'd7, 32'hCAFE_0007});
    tick();
    lsu_valid = 1'b0;
    expectBit("sb_busy_while_wen", rs1_busy, 1'b1);
    tick();
    expectBit("sb_busy_after_commit", rs1_busy, 1'b0);
  endtask

  task automatic test_set_wins;
    issue_valid = 1'b1; issue_rd = 5'd9; q_rs1 = 5'd9;
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_9999;
    sbQ.push_back({5'd9, 32'h0000_9999});
    tick();
    exu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    expectBit("set_wins_busy9", rs1_busy, 1'b1);
  endtask

  task automatic test_rd_zero;
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hABCD_0000;
    #1;
    expectBit("rd0_exu_ready", exu_ready, 1'b1);
    tick();
    exu_valid = 1'b0;
    expectBit("rd0_w_en", w_en, 1'b0);
    testsRun++;
    if (w_rd_addr !== 5'd0 || w_data !== 32'hABCD_0000) begin
      testsFailed++;
      $display("[TB] FAIL rd0_capture: got addr=%0d data=%h, expected 0/abcd0000", w_rd_addr, w_data);
    end
    issue_valid = 1'b1; issue_rd = 5'd0; q_rs1 = 5'd0;
    tick();
    issue_valid = 1'b0;
    expectBit("rd0_issue_busy", rs1_busy, 1'b0);
  endtask

  task automatic test_flush;
    logic [4:0] regs [3];
    regs[0] = 5'd2; regs[1] = 5'd6; regs[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = regs[i];
      tick();
    end
    issue_valid = 1'b0;
    q_rs1 = 5'd2; q_rs2 = 5'd31;
    #1;
    expectBit("flush_pre_busy2", rs1_busy, 1'b1);
    expectBit("flush_pre_busy31", rs2_busy, 1'b1);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd13;
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_rs1 = regs[i];
      #1;
      expectBit($sformatf("flush_busy%0d", regs[i]), rs1_busy, 1'b0);
    end
    q_rs1 = 5'd9; q_rs2 = 5'd13;
    #1;
    expectBit("flush_busy9", rs1_busy, 1'b0);
    expectBit("flush_issue13_kept", rs2_busy, 1'b1);
  endtask

  task automatic test_reset_midop;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'h1212_1212;
    sbQ.push_back({5'd12, 32'h1212_1212});
    tick();
    expectBit("midop_w_en_before", w_en, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expectBit("midop_w_en_reset", w_en, 1'b0);
    expectBit("midop_exu_ready_reset", exu_ready, 1'b0);
    q_rs1 = 5'd13;
    #1;
    expectBit("midop_busy13_reset", rs1_busy, 1'b0);
    rst_n = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2020_2020;
    #1;
    expectBit("midop_conflict_lsu", lsu_ready, 1'b1);
    expectBit("midop_conflict_exu", exu_ready, 1'b0);
    sbQ.push_back({5'd20, 32'h2020_2020});
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_single_exu();
    test_conflict();
    test_scoreboard();
    test_set_wins();
    test_rd_zero();
    test_flush();
    test_reset_midop();
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL missing_writes: got %0d writes still pending, expected 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
